// File: rtl/alu593_sched.sv
// Two-port request scheduler in front of a shared multi-cycle ALU.
// Round-robin arbitration, one operation in flight, bypass for no-ops and
// illegal opcodes, and a watchdog that aborts an ALU command that never
// completes.

module alu593_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_A,
  input  logic [7:0]  req0_B,
  input  logic [7:0]  req1_A,
  input  logic [7:0]  req1_B,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [3:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  // Last ISSUE cycle index; the command is abandoned after this many cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_served;
  logic        port_id;
  logic [7:0]  tcount;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel_port;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic [3:0]  sel_op;
  logic        sel_legal;
  logic        sel_illegal;

  // Round-robin winner selection and decode of the winning request's opcode.
  always_comb begin
    grant0      = req0_valid && (!req1_valid || last_served);
    grant1      = req1_valid && (!req0_valid || !last_served);
    req0_ready  = reset_n && (state == IDLE) && grant0;
    req1_ready  = reset_n && (state == IDLE) && grant1;
    accept      = req0_ready || req1_ready;
    sel_port    = grant1;
    sel_a       = grant1 ? req1_A  : req0_A;
    sel_b       = grant1 ? req1_B  : req0_B;
    sel_op      = grant1 ? req1_op : req0_op;
    sel_legal   = (sel_op != 4'd0) && (sel_op < 4'd8);
    sel_illegal = (sel_op > 4'd8);
  end

  assign busy = (state != IDLE);

  // Scheduler FSM: accept, drive the ALU or bypass it, and pulse the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      port_id     <= 1'b0;
      tcount      <= 8'd0;
      alu_start   <= 1'b0;
      alu_A       <= 8'd0;
      alu_B       <= 8'd0;
      alu_op      <= 4'd0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp_result  <= 16'd0;
      rsp_err     <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_served <= sel_port;
            port_id     <= sel_port;
            if (sel_legal) begin
              alu_A     <= sel_a;
              alu_B     <= sel_b;
              alu_op    <= sel_op;
              alu_start <= 1'b1;
              tcount    <= 8'd0;
              state     <= ISSUE;
            end else begin
              rsp_result <= 16'd0;
              rsp_err    <= sel_illegal;
              rsp0_valid <= !sel_port;
              rsp1_valid <= sel_port;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            alu_start  <= 1'b0;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp0_valid <= !port_id;
            rsp1_valid <= port_id;
            state      <= RESP;
          end else if (tcount == TIMEOUT_LAST) begin
            alu_start  <= 1'b0;
            rsp_result <= 16'd0;
            rsp_err    <= 1'b1;
            rsp0_valid <= !port_id;
            rsp1_valid <= port_id;
            state      <= RESP;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu593_sched.md
ALU593_SCHED -- requirements
Module: alu593_sched

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max cycles alu_start may stay high awaiting alu_done before abort (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation accepted this cycle when valid&ready.
REQ-006 req0_A, req0_B, req1_A, req1_B  input  8 each  operands.
REQ-007 req0_op, req1_op  input  4 each  opcode; no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, sp_func1=5, sp_func2=6, sp_func3=7, no_op1=8, 9..15 illegal.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  one-cycle completion pulse to requester N.
REQ-009 rsp_result  output  16  result for the pulsing rsp port.
REQ-010 rsp_err  output  1  valid with rsp*_valid; 1 = illegal opcode or timeout.
REQ-011 alu_start, alu_A[7:0], alu_B[7:0], alu_op[3:0]  output  shared ALU command.
REQ-012 alu_done  input  1  ALU completion; alu_result  input  16  valid when alu_done=1.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, RESP; exactly one request in flight at any time.
REQ-015 IDLE: ready asserted combinationally only to the arbitration winner; loser's ready=0; no ready in any other state.
REQ-016 Arbitration round-robin: both valid -> grant the port not served last; single valid -> grant it regardless of pointer.
REQ-017 last_served pointer updates on each acceptance only.
REQ-018 On accept (cycle T) latch port id, A, B, op; requester may change inputs from T+1.
REQ-019 Legal ALU op (1..7) -> ISSUE at T+1: alu_start=1, alu_A/alu_B/alu_op hold latched values, stable until start drops.
REQ-020 ISSUE: alu_start held high until cycle alu_done=1 is sampled; that cycle capture alu_result, go RESP, drop alu_start next cycle.
REQ-021 no_op/no_op1 -> bypass ALU: RESP at T+1, result 0, err 0, alu_start never asserted.
REQ-022 Illegal op (9..15) -> bypass ALU: RESP at T+1, result 0, err 1.
REQ-023 Timeout counter 8 bits, cleared on entry to ISSUE, +1 per ISSUE cycle; reaching TIMEOUT without alu_done -> drop alu_start, RESP with result 0, err 1.
REQ-024 alu_done and timeout in same cycle -> alu_done wins, err 0.
REQ-025 RESP lasts exactly one cycle: rspN_valid=1 for owner only, then IDLE; new accept possible in IDLE cycle following RESP.
REQ-026 alu_done while not in ISSUE is ignored.
REQ-027 Result path zero-extension/truncation not performed; alu_result passed unchanged 16 bits.
REQ-028 Latency: legal op done at cycle D -> rsp at D+1; bypass op accepted at T -> rsp at T+1.
REQ-029 rsp_result and rsp_err hold last response value between responses.

Reset
REQ-030 reset_n low: state=IDLE, all ready/rsp_valid/rsp_err/alu_start/busy=0, alu_A/alu_B/alu_op/rsp_result=0, timeout counter=0, last_served=1 (port 0 has first priority).
REQ-031 Reset mid-operation aborts it immediately; no response issued for the aborted request; alu_start drops asynchronously.
REQ-032 After reset_n rises, first accept possible on the first rising edge with valid input.

Verification
REQ-033 Port 0 add_op A=8'h12 B=8'h34, ALU done after 3 cycles with 16'h0046 -> rsp0_valid pulse, rsp_result=16'h0046, rsp_err=0, rsp1_valid=0.
REQ-034 Both ports valid continuously after reset -> grant order 0,1,0,1; no port granted twice consecutively while the other waits.
REQ-035 Port 1 no_op1 -> rsp1_valid at T+1, result 0, err 0, alu_start never high.
REQ-036 Port 0 op=4'hC -> rsp0_valid at T+1, err 1, alu_start never high.
REQ-037 mul_op A=8'hFF B=8'hFF, alu_done withheld -> alu_start drops after TIMEOUT=64 cycles, rsp err=1 result 0; alu_done arriving later ignored.
REQ-038 reset_n pulsed low during ISSUE -> alu_start=0 and busy=0 immediately, no rsp pulse, next request served from port 0 priority.
